// File: rtl/oled_pkg.sv
// ============================================================================
// Module : oled_pkg
// Brief  : Shared screen geometry, digit-select encoding and freeze-state type
//          for the OLED control synchroniser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package oled_pkg;

    localparam int SCREEN_W   = 96;
    localparam int SCREEN_H   = 64;
    localparam int NUM_PIXELS = 6144;
    localparam int LAST_PIXEL = 6143;

    localparam logic [1:0] NUM_NONE = 2'd0;
    localparam logic [1:0] NUM_1    = 2'd1;
    localparam logic [1:0] NUM_2    = 2'd2;
    localparam logic [1:0] NUM_3    = 2'd3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } frz_state_t;

    // One-hot switch group to digit; anything not strictly one-hot shows nothing.
    function automatic logic [1:0] decode_num(input logic [2:0] i_bits);
        logic [1:0] w_num;
        case (i_bits)
            3'b001:  w_num = NUM_1;
            3'b010:  w_num = NUM_2;
            3'b100:  w_num = NUM_3;
            default: w_num = NUM_NONE;
        endcase
        return w_num;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oled_ctrl_sync_sw_debounce.sv
// ============================================================================
// Module : sw_debounce
// Brief  : Two-flop synchroniser plus tick-sampled debouncer for one switch.
//          Debounce logic present only when OLED_CTRL_SYNC_DEBOUNCE_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sw_debounce #(
    parameter int SAMPLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    input  logic i_tick,
    output logic o_level
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
        end
    end

`ifdef OLED_CTRL_SYNC_DEBOUNCE_EN
    localparam int CW = $clog2(SAMPLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;

    // Counts consecutive samples disagreeing with the accepted level; any
    // agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (i_tick) begin
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(SAMPLES - 1)) begin
                r_level <= r_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
`else
    localparam int unused_samples = SAMPLES;
    logic w_unused_tick;
    assign w_unused_tick = i_tick;
    assign o_level       = r_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/oled_ctrl_sync.sv
// ============================================================================
// Module : oled_ctrl_sync
// Brief  : Switch sync/debounce, freeze FSM, frame-aligned control commit and
//          pixel index to (x,y). Debounce enabled by OLED_CTRL_SYNC_DEBOUNCE_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oled_ctrl_sync
    import oled_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 65536,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw,
    input  logic [12:0] pixel_index,
    input  logic        sample_pixel,
    output logic [6:0]  x,
    output logic [5:0]  y,
    output logic        pixel_valid,
    output logic        border_on,
    output logic [1:0]  num_sel,
    output logic        frame_start,
    output logic [15:0] led
);

    logic        w_tick;
    logic [15:0] w_db;

`ifdef OLED_CTRL_SYNC_DEBOUNCE_EN
    localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [TW-1:0] r_tick_cnt;

    assign w_tick = (r_tick_cnt == TW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end
`else
    localparam int unused_cycles = DEBOUNCE_CYCLES;
    assign w_tick = 1'b0;
`endif

    for (genvar gi = 0; gi < 16; gi++) begin : g_sw
        sw_debounce #(
            .SAMPLES (DEBOUNCE_SAMPLES)
        ) u_db (
            .clk     (clk),
            .rst     (reset),
            .i_sw    (sw[gi]),
            .i_tick  (w_tick),
            .o_level (w_db[gi])
        );
    end

    frz_state_t r_state;
    frz_state_t w_state_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_RUN:    if (w_db[15])  w_state_nx = ST_FROZEN;
            ST_FROZEN: if (!w_db[15]) w_state_nx = ST_RUN;
            default:   w_state_nx = ST_RUN;
        endcase
    end

    // Pending controls are registered so a commit in the same cycle as a
    // freeze transition always sees the values from before that cycle.
    logic       r_pend_border;
    logic [1:0] r_pend_num;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_border <= 1'b0;
            r_pend_num    <= NUM_NONE;
        end else if (r_state == ST_RUN) begin
            r_pend_border <= w_db[8];
            r_pend_num    <= decode_num(w_db[3:1]);
        end
    end

    // Restoring division by 96 against constant multiples 96<<b.
    logic [12:0] w_rem;
    logic [5:0]  w_row;

    always_comb begin
        w_rem = pixel_index;
        w_row = '0;
        for (int b = 5; b >= 0; b--) begin
            if (w_rem >= (13'(SCREEN_W) << b)) begin
                w_rem    = w_rem - (13'(SCREEN_W) << b);
                w_row[b] = 1'b1;
            end
        end
    end

    logic w_unused_rem;
    assign w_unused_rem = |w_rem[12:7];

    logic w_in_range;
    logic w_commit;

    assign w_in_range = sample_pixel && (pixel_index < 13'(NUM_PIXELS));
    assign w_commit   = sample_pixel && (pixel_index == 13'(LAST_PIXEL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            pixel_valid <= 1'b0;
            border_on   <= 1'b0;
            num_sel     <= NUM_NONE;
            frame_start <= 1'b0;
        end else begin
            pixel_valid <= w_in_range;
            frame_start <= w_commit;
            if (w_in_range) begin
                x <= w_rem[6:0];
                y <= w_row;
            end
            if (w_commit) begin
                border_on <= r_pend_border;
                num_sel   <= r_pend_num;
            end
        end
    end

    assign led = {(r_state == ST_FROZEN), w_db[14:0]};

endmodule

`default_nettype wire
